// File: rtl/dht11_data_proc.sv
// DHT11 sample post-processor: edge-detected capture, range check, 4-sample
// moving average, serial binary-to-BCD conversion, comfort flags with
// hysteresis, error counter and stale-data detection.
module dht11_data_proc #(
    parameter int unsigned STALE_TIMEOUT = 50000000,
    parameter int unsigned TEMP_HOT      = 30,
    parameter int unsigned TEMP_COLD     = 15,
    parameter int unsigned HUM_WET       = 80,
    parameter int unsigned HUM_DRY       = 30,
    parameter int unsigned HYST          = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [15:0] humidity_in,
    input  logic [15:0] temperature_in,
    output logic [7:0]  hum_avg,
    output logic [7:0]  temp_avg,
    output logic [11:0] hum_bcd,
    output logic [11:0] temp_bcd,
    output logic [3:0]  comfort,
    output logic        data_ready,
    output logic        stale,
    output logic [7:0]  err_count
);

    localparam int unsigned STALE_W = $clog2(STALE_TIMEOUT + 1);
    localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_TIMEOUT);
    localparam logic [7:0] HOT_SET  = 8'(TEMP_HOT);
    localparam logic [7:0] HOT_CLR  = 8'(TEMP_HOT - HYST);
    localparam logic [7:0] COLD_SET = 8'(TEMP_COLD);
    localparam logic [7:0] COLD_CLR = 8'(TEMP_COLD + HYST);
    localparam logic [7:0] WET_SET  = 8'(HUM_WET);
    localparam logic [7:0] WET_CLR  = 8'(HUM_WET - HYST);
    localparam logic [7:0] DRY_SET  = 8'(HUM_DRY);
    localparam logic [7:0] DRY_CLR  = 8'(HUM_DRY + HYST);

    typedef enum logic [2:0] {IDLE, ACCUM, CONV, CLASS, DONE} state_t;

    state_t              state, state_n;
    logic                valid_r, valid_r2;
    logic [15:0]         data_r;
    logic                pend_valid;
    logic [15:0]         pend_data;
    logic [15:0]         cap;
    logic [7:0]          win_h [4];
    logic [7:0]          win_t [4];
    logic                win_full;
    logic [7:0]          sh_h, sh_t;
    logic [11:0]         wk_h, wk_t;
    logic [2:0]          bit_cnt;
    logic [STALE_W-1:0]  stale_cnt;

    logic                sample_evt_c;
    logic                sel_valid_c, sel_ok_c, accept_c, reject_c;
    logic [15:0]         sel_data_c;
    logic [7:0]          nwin_h_c [4];
    logic [7:0]          nwin_t_c [4];
    logic [9:0]          sum_h_c, sum_t_c;
    logic [11:0]         step_h_c, step_t_c;
    logic [3:0]          comfort_n_c;
    logic [STALE_W-1:0]  stale_cnt_n_c;
    logic                unused_frac;

    // Decimal bytes of the sensor are not used
    assign unused_frac = ^{humidity_in[7:0], temperature_in[7:0]};

    // One shift-add-3 double-dabble step over three BCD digits
    function automatic logic [11:0] dd_step(input logic [11:0] bcd, input logic msb);
        logic [11:0] adj;
        adj = bcd;
        for (int d = 0; d < 3; d++) begin
            if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
        end
        return 12'({adj, msb});
    endfunction

    // Register raw valid and integer bytes for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r  <= 1'b0;
            valid_r2 <= 1'b0;
            data_r   <= '0;
        end else begin
            valid_r  <= valid_in;
            valid_r2 <= valid_r;
            data_r   <= {humidity_in[15:8], temperature_in[15:8]};
        end
    end

    // Sample selection and range check; a fresh event beats a pending one
    always_comb begin
        sample_evt_c = valid_r & ~valid_r2;
        sel_valid_c  = sample_evt_c | pend_valid;
        sel_data_c   = sample_evt_c ? data_r : pend_data;
        sel_ok_c     = (sel_data_c[15:8] <= 8'd100) && (sel_data_c[7:0] <= 8'd50);
        accept_c     = (state == IDLE) && sel_valid_c && sel_ok_c;
        reject_c     = (state == IDLE) && sel_valid_c && !sel_ok_c;
    end

    // Next window contents and sums for the averaging step
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nwin_h_c[i] = cap[15:8];
            nwin_t_c[i] = cap[7:0];
        end
        if (win_full) begin
            for (int i = 1; i < 4; i++) begin
                nwin_h_c[i] = win_h[i-1];
                nwin_t_c[i] = win_t[i-1];
            end
        end
        sum_h_c = 10'(nwin_h_c[0]) + 10'(nwin_h_c[1]) + 10'(nwin_h_c[2]) + 10'(nwin_h_c[3]);
        sum_t_c = 10'(nwin_t_c[0]) + 10'(nwin_t_c[1]) + 10'(nwin_t_c[2]) + 10'(nwin_t_c[3]);
        step_h_c = dd_step(wk_h, sh_h[7]);
        step_t_c = dd_step(wk_t, sh_t[7]);
    end

    // Comfort flags with hysteresis; opposite flags are mutually exclusive
    always_comb begin
        comfort_n_c = comfort;
        if (temp_avg >= HOT_SET)       comfort_n_c[3] = 1'b1;
        else if (temp_avg < HOT_CLR)   comfort_n_c[3] = 1'b0;
        if (temp_avg <= COLD_SET)      comfort_n_c[2] = 1'b1;
        else if (temp_avg > COLD_CLR)  comfort_n_c[2] = 1'b0;
        if (hum_avg >= WET_SET)        comfort_n_c[1] = 1'b1;
        else if (hum_avg < WET_CLR)    comfort_n_c[1] = 1'b0;
        if (hum_avg <= DRY_SET)        comfort_n_c[0] = 1'b1;
        else if (hum_avg > DRY_CLR)    comfort_n_c[0] = 1'b0;
        if (comfort_n_c[3]) comfort_n_c[2] = 1'b0;
        if (comfort_n_c[1]) comfort_n_c[0] = 1'b0;
    end

    // Stale counter: clears on accepted sample, otherwise saturates
    always_comb begin
        stale_cnt_n_c = stale_cnt;
        if (accept_c)                    stale_cnt_n_c = '0;
        else if (stale_cnt != STALE_MAX) stale_cnt_n_c = stale_cnt + STALE_W'(1);
    end

    // FSM next state
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept_c) state_n = ACCUM;
            ACCUM:   state_n = CONV;
            CONV:    if (bit_cnt == 3'd7) state_n = CLASS;
            CLASS:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Pending slot, capture, error and stale bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_data  <= '0;
            cap        <= '0;
            err_count  <= '0;
            stale_cnt  <= '0;
            stale      <= 1'b0;
        end else begin
            if (state != IDLE) begin
                if (sample_evt_c) begin
                    pend_valid <= 1'b1;
                    pend_data  <= data_r;
                end
            end else if (sel_valid_c) begin
                pend_valid <= 1'b0;
            end
            if (accept_c) cap <= sel_data_c;
            if (reject_c && err_count != 8'hFF) err_count <= err_count + 8'd1;
            stale_cnt <= stale_cnt_n_c;
            stale     <= (stale_cnt_n_c == STALE_MAX);
        end
    end

    // Averaging window, BCD conversion, classification and ready pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                win_h[i] <= '0;
                win_t[i] <= '0;
            end
            win_full   <= 1'b0;
            hum_avg    <= '0;
            temp_avg   <= '0;
            sh_h       <= '0;
            sh_t       <= '0;
            wk_h       <= '0;
            wk_t       <= '0;
            bit_cnt    <= '0;
            hum_bcd    <= '0;
            temp_bcd   <= '0;
            comfort    <= '0;
            data_ready <= 1'b0;
        end else begin
            data_ready <= (state == CLASS);
            case (state)
                ACCUM: begin
                    for (int i = 0; i < 4; i++) begin
                        win_h[i] <= nwin_h_c[i];
                        win_t[i] <= nwin_t_c[i];
                    end
                    win_full <= 1'b1;
                    hum_avg  <= 8'(sum_h_c >> 2);
                    temp_avg <= 8'(sum_t_c >> 2);
                    sh_h     <= 8'(sum_h_c >> 2);
                    sh_t     <= 8'(sum_t_c >> 2);
                    wk_h     <= '0;
                    wk_t     <= '0;
                    bit_cnt  <= '0;
                end
                CONV: begin
                    sh_h    <= {sh_h[6:0], 1'b0};
                    sh_t    <= {sh_t[6:0], 1'b0};
                    wk_h    <= step_h_c;
                    wk_t    <= step_t_c;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        hum_bcd  <= step_h_c;
                        temp_bcd <= step_t_c;
                    end
                end
                CLASS: comfort <= comfort_n_c;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_data_proc.sv
// Scoreboard bench for dht11_data_proc: a behavioural model predicts each
// accepted sample's averages, BCD and comfort flags; a monitor pops and
// compares on every data_ready pulse.
module tb_dht11_data_proc;

    typedef struct packed {
        logic [7:0]  h_avg;
        logic [7:0]  t_avg;
        logic [11:0] h_bcd;
        logic [11:0] t_bcd;
        logic [3:0]  cf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [15:0] humidity_in;
    logic [15:0] temperature_in;
    logic [7:0]  hum_avg, temp_avg;
    logic [11:0] hum_bcd, temp_bcd;
    logic [3:0]  comfort;
    logic        data_ready, stale;
    logic [7:0]  err_count;

    int   n_checks = 0;
    int   n_err = 0;
    int   drdy_cnt = 0;
    int   cyc = 0;
    int   ev_cyc = 0;
    int   ready_cyc = 0;
    exp_t sb[$];
    exp_t m_last;
    int   m_h[4];
    int   m_t[4];
    bit   m_full;
    logic [3:0] m_cf;

    dht11_data_proc #(.STALE_TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .humidity_in(humidity_in), .temperature_in(temperature_in),
        .hum_avg(hum_avg), .temp_avg(temp_avg),
        .hum_bcd(hum_bcd), .temp_bcd(temp_bcd),
        .comfort(comfort), .data_ready(data_ready),
        .stale(stale), .err_count(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic model_reset();
        m_full = 1'b0;
        m_cf   = 4'b0000;
        m_last = '0;
        sb.delete();
    endtask

    task automatic model_accept(input int h, input int t);
        int ah, at;
        logic hot, cold, wet, dry;
        exp_t e;
        if (!m_full) begin
            for (int i = 0; i < 4; i++) begin
                m_h[i] = h;
                m_t[i] = t;
            end
            m_full = 1'b1;
        end else begin
            for (int i = 3; i > 0; i--) begin
                m_h[i] = m_h[i-1];
                m_t[i] = m_t[i-1];
            end
            m_h[0] = h;
            m_t[0] = t;
        end
        ah = (m_h[0] + m_h[1] + m_h[2] + m_h[3]) / 4;
        at = (m_t[0] + m_t[1] + m_t[2] + m_t[3]) / 4;
        {hot, cold, wet, dry} = m_cf;
        if (at >= 30) hot = 1'b1; else if (at < 28) hot = 1'b0;
        if (at <= 15) cold = 1'b1; else if (at > 17) cold = 1'b0;
        if (ah >= 80) wet = 1'b1; else if (ah < 78) wet = 1'b0;
        if (ah <= 30) dry = 1'b1; else if (ah > 32) dry = 1'b0;
        if (hot) cold = 1'b0;
        if (wet) dry = 1'b0;
        m_cf    = {hot, cold, wet, dry};
        e.h_avg = 8'(ah);
        e.t_avg = 8'(at);
        e.h_bcd = to_bcd(ah);
        e.t_bcd = to_bcd(at);
        e.cf    = m_cf;
        m_last  = e;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every ready pulse must match the oldest prediction
    always @(negedge clk) begin
        if (data_ready === 1'b1) begin
            drdy_cnt++;
            ready_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("hum_avg", 32'(hum_avg), 32'(e.h_avg));
                check("temp_avg", 32'(temp_avg), 32'(e.t_avg));
                check("hum_bcd", 32'(hum_bcd), 32'(e.h_bcd));
                check("temp_bcd", 32'(temp_bcd), 32'(e.t_bcd));
                check("comfort", 32'(comfort), 32'(e.cf));
            end
        end
    end

    // One-cycle valid pulse; ev_cyc records the edge that registers it
    task automatic send(input int h, input int t);
        @(negedge clk);
        humidity_in    = {8'(h), 8'h00};
        temperature_in = {8'(t), 8'h00};
        valid_in       = 1'b1;
        @(negedge clk);
        ev_cyc   = cyc;
        valid_in = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int start, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (drdy_cnt >= start + target) break;
            @(negedge clk);
        end
        check(tag, 32'(drdy_cnt >= start + target), 32'd1);
    endtask

    task automatic do_sample(input int h, input int t);
        int start;
        start = drdy_cnt;
        model_accept(h, t);
        send(h, t);
        wait_ready("ready_timeout", start, 1, 30);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_hum_avg"}, 32'(hum_avg), 32'd0);
        check({tag, "_temp_avg"}, 32'(temp_avg), 32'd0);
        check({tag, "_bcd"}, 32'({hum_bcd, temp_bcd}), 32'd0);
        check({tag, "_comfort"}, 32'(comfort), 32'd0);
        check({tag, "_ready"}, 32'(data_ready), 32'd0);
        check({tag, "_stale"}, 32'(stale), 32'd0);
        check({tag, "_err"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        int start;
        rst = 1'b1;
        valid_in = 1'b0;
        humidity_in = '0;
        temperature_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;

        // First sample fills the window; latency is 11 edges
        start = drdy_cnt;
        model_accept(60, 25);
        send(60, 25);
        wait_ready("first_timeout", start, 1, 30);
        check("latency", 32'(ready_cyc - ev_cyc), 32'd11);
        check("first_hum_bcd", 32'(hum_bcd), 32'h060);
        check("first_temp_bcd", 32'(temp_bcd), 32'h025);
        repeat (2) @(negedge clk);

        // Temperature climbs to hot, then falls through the hysteresis band
        do_sample(60, 31);
        check("t26_avg", 32'(temp_avg), 32'd26);
        repeat (3) do_sample(60, 31);
        check("t31_avg", 32'(temp_avg), 32'd31);
        check("t31_hot", 32'(comfort[3]), 32'd1);
        do_sample(60, 29);
        check("t30_avg", 32'(temp_avg), 32'd30);
        check("t30_hot", 32'(comfort[3]), 32'd1);
        do_sample(60, 27);
        do_sample(60, 27);
        check("t28_avg", 32'(temp_avg), 32'd28);
        check("t28_hot_held", 32'(comfort[3]), 32'd1);
        do_sample(60, 27);
        check("t27_avg", 32'(temp_avg), 32'd27);
        check("t27_hot_clr", 32'(comfort[3]), 32'd0);

        // Humidity rises into wet and back out
        repeat (4) do_sample(90, 20);
        check("wet_set", 32'(comfort[1]), 32'd1);
        repeat (4) do_sample(20, 20);
        check("dry_set", 32'(comfort[1:0]), 32'b01);

        // Out-of-range samples are counted and leave the window untouched
        start = drdy_cnt;
        send(101, 25);
        repeat (14) @(negedge clk);
        check("rej_err1", 32'(err_count), 32'd1);
        check("rej_no_ready", 32'(drdy_cnt - start), 32'd0);
        check("rej_hum_avg", 32'(hum_avg), 32'(m_last.h_avg));
        check("rej_temp_avg", 32'(temp_avg), 32'(m_last.t_avg));
        for (int i = 0; i < 300; i++) send(60, 51);
        repeat (3) @(negedge clk);
        check("err_sat", 32'(err_count), 32'd255);
        check("rej_no_ready2", 32'(drdy_cnt - start), 32'd0);
        check("stale_after_rejects", 32'(stale), 32'd1);

        // Two events during conversion: only the last one is processed
        start = drdy_cnt;
        model_accept(40, 20);
        send(40, 20);
        send(45, 22);
        send(50, 24);
        model_accept(50, 24);
        wait_ready("pend_timeout", start, 2, 40);
        repeat (20) @(negedge clk);
        check("pend_ready_count", 32'(drdy_cnt - start), 32'd2);
        check("pend_stale_clr", 32'(stale), 32'd0);
        check("pend_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-conversion aborts; window restarts empty
        start = drdy_cnt;
        send(50, 20);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero_outputs("abort");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (99) @(negedge clk);
        check("stale_99", 32'(stale), 32'd0);
        @(negedge clk);
        check("stale_100", 32'(stale), 32'd1);
        check("abort_no_ready", 32'(drdy_cnt - start), 32'd0);
        do_sample(70, 40);
        check("restart_temp_avg", 32'(temp_avg), 32'd40);
        check("restart_stale", 32'(stale), 32'd0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
